// File: rtl/param_fifo_pkg.sv
// Shared helpers and default thresholds for param_fifo.
// Pointer and count widths are derived here so the top and the RAM agree.
package param_fifo_pkg;

  // Default almost-empty threshold, in entries.
  localparam int unsigned DEF_AE_LEVEL = 1;

  // Default almost-full threshold sits this many entries below full.
  localparam int unsigned DEF_AF_MARGIN = 1;

  // Address width for a RAM of 'depth' entries (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/param_fifo_ram.sv
// fifo_ram: DATA_WIDTH x DEPTH storage, one synchronous write port and one
// asynchronous (combinational) read port.
module fifo_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry on an enabled clock edge.
  // NOTE: storage has no reset; occupancy is tracked by the pointers and
  // count, so stale words are never presented and RAM maps to plain memory.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Zero-latency read of the entry at the read pointer.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// param_fifo: parameterised FIFO with same-cycle bypass, full-FIFO
// push-while-pop, synchronous flush and optional watermark flags.
// Optional feature macro: PARAM_FIFO_WATERMARK_EN (almost_full_o /
// almost_empty_o driven from the registered count; tied to 0 otherwise).
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - DEF_AF_MARGIN,
  parameter int unsigned AE_LEVEL   = DEF_AE_LEVEL
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH-1:0]            push_data_i,
  input  logic                             push_valid_i,
  output logic                             push_grant_o,
  input  logic                             pop_grant_i,
  output logic [DATA_WIDTH-1:0]            pop_data_o,
  output logic                             pop_valid_o,
  input  logic                             flush_i,
  output logic [cnt_width(FIFO_DEPTH)-1:0] count_o,
  output logic                             almost_full_o,
  output logic                             almost_empty_o
);

  localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);
  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2) begin : g_depth_check
    $error("param_fifo: FIFO_DEPTH must be at least 2");
  end

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  logic empty;
  logic full;
  logic push_grant;
  logic pop_valid;
  logic bypass;
  logic push_xfer;
  logic pop_xfer;
  logic bypass_pop;
  logic ram_we;

  // Handshake decode. Outputs are forced idle while rst_n is low so the
  // reset values appear immediately, not at the next edge.
  assign empty      = (count == '0);
  assign full       = (count == DEPTH_CNT);
  assign push_grant = rst_n && !flush_i && (!full || pop_grant_i);
  assign pop_valid  = rst_n && !flush_i && (!empty || push_valid_i);
  assign bypass     = empty && push_valid_i;
  assign push_xfer  = push_valid_i && push_grant;
  assign pop_xfer   = pop_valid && pop_grant_i;
  // A word that arrives and leaves in the same cycle never touches the RAM.
  assign bypass_pop = bypass && pop_xfer;
  assign ram_we     = push_xfer && !bypass_pop && !flush_i;

  assign push_grant_o = push_grant;
  assign pop_valid_o  = pop_valid;
  assign count_o      = count;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_W     (PTR_W)
  ) u_fifo_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (wr_ptr),
    .wr_data (push_data_i),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );

  // Read-data mux: zero when idle, bypass word when empty, else RAM head.
  // NOTE: every branch assigns pop_data_o after a default, so no latch forms.
  always_comb begin
    pop_data_o = '0;
    if (pop_valid) begin
      pop_data_o = bypass ? push_data_i : ram_rd_data;
    end
  end

  // Pointer and occupancy state; flush and reset both return to empty.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_xfer) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_xfer) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push_xfer, pop_xfer})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef PARAM_FIFO_WATERMARK_EN
  if (AF_LEVEL > FIFO_DEPTH || AE_LEVEL > FIFO_DEPTH) begin : g_level_check
    $error("param_fifo: watermark levels must not exceed FIFO_DEPTH");
  end

  // Watermarks compare the registered count; reset forces 0 / 1.
  assign almost_full_o  = rst_n && (32'(count) >= AF_LEVEL);
  assign almost_empty_o = !rst_n || (32'(count) <= AE_LEVEL);
`else
  if (AF_LEVEL > FIFO_DEPTH || AE_LEVEL > FIFO_DEPTH) begin : g_level_check
    $warning("param_fifo: watermark levels out of range (flags disabled)");
  end

  // Watermarks disabled: ports kept, tied low.
  assign almost_full_o  = 1'b0;
  assign almost_empty_o = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo (DATA_WIDTH=8, FIFO_DEPTH=5,
// AF_LEVEL=4, AE_LEVEL=1). A queue-based reference model predicts the
// handshake and occupancy; expected pop words go into a scoreboard that a
// separate monitor drains whenever the DUT completes a pop.
module tb_param_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          push_valid = 1'b0;
  logic          pop_grant = 1'b0;
  logic          flush = 1'b0;

  logic          push_grant_o;
  logic [DW-1:0] pop_data_o;
  logic          pop_valid_o;
  logic [2:0]    count_o;
  logic          almost_full_o;
  logic          almost_empty_o;

  param_fifo #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .push_data_i    (push_data),
    .push_valid_i   (push_valid),
    .push_grant_o   (push_grant_o),
    .pop_grant_i    (pop_grant),
    .pop_data_o     (pop_data_o),
    .pop_valid_o    (pop_valid_o),
    .flush_i        (flush),
    .count_o        (count_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] model_q [$];  // FIFO contents as the spec defines them
  logic [DW-1:0] sb_q    [$];  // words the DUT must pop, in order
  logic [DW-1:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_af(input int c);
`ifdef PARAM_FIFO_WATERMARK_EN
    return c >= AF;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_ae(input int c);
`ifdef PARAM_FIFO_WATERMARK_EN
    return c <= AE;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_ae_reset();
`ifdef PARAM_FIFO_WATERMARK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // One clock of stimulus: drive after the edge, predict, check at negedge.
  task automatic cycle(input logic pv, input logic [DW-1:0] d,
                       input logic pg, input logic fl);
    int            c;
    logic          epg;
    logic          epv;
    logic [DW-1:0] ed;
    @(posedge clk);
    #1;
    push_valid = pv;
    push_data  = d;
    pop_grant  = pg;
    flush      = fl;
    c   = model_q.size();
    epg = !fl && (c < DEPTH || pg);
    epv = !fl && (c > 0 || pv);
    ed  = !epv ? '0 : (c > 0 ? model_q[0] : d);
    if (epv && pg) sb_q.push_back(ed);
    if (fl) begin
      model_q.delete();
    end else begin
      if (epv && pg && c > 0) void'(model_q.pop_front());
      if (pv && epg && !(epv && pg && c == 0)) model_q.push_back(d);
    end
    @(negedge clk);
    check("push_grant", push_grant_o, epg);
    check("pop_valid", pop_valid_o, epv);
    check("count", count_o, c);
    check("almost_full", almost_full_o, exp_af(c));
    check("almost_empty", almost_empty_o, exp_ae(c));
    if (!(epv && pg)) check("pop_data_idle", pop_data_o, ed);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: every completed pop must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && pop_valid_o && pop_grant) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected no pop at %0t",
                 pop_data_o, $time);
      end else begin
        mon_exp = sb_q.pop_front();
        check("pop_data", pop_data_o, mon_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst_n is low, even with active stimulus.
    push_valid = 1'b1;
    pop_grant  = 1'b1;
    push_data  = 8'h3C;
    #2;
    check("rst_push_grant", push_grant_o, 1'b0);
    check("rst_pop_valid", pop_valid_o, 1'b0);
    check("rst_pop_data", pop_data_o, 8'h00);
    check("rst_count", count_o, 3'd0);
    check("rst_almost_full", almost_full_o, 1'b0);
    check("rst_almost_empty", almost_empty_o, exp_ae_reset());
    push_valid = 1'b0;
    pop_grant  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Fill to full, attempt an extra push, then drain in order.
    for (int i = 1; i <= 5; i++) cycle(1'b1, DW'(i * 8'h11), 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    idle();

    // Bypass on an empty FIFO.
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    idle();

    // Full FIFO accepts a push while popping.
    for (int i = 1; i <= 5; i++) cycle(1'b1, DW'(i * 8'h11), 1'b0, 1'b0);
    cycle(1'b1, 8'h66, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    idle();

    // Pointer wrap at steady occupancy 3.
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, DW'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    idle();

    // Flush blocks a concurrent push and empties the FIFO.
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b0, 1'b1);
    idle();

    // Asynchronous reset mid-push at count 2.
    for (int i = 0; i < 2; i++) cycle(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    push_valid = 1'b1;
    push_data  = 8'hC3;
    pop_grant  = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_push_grant", push_grant_o, 1'b0);
    check("mid_rst_pop_valid", pop_valid_o, 1'b0);
    check("mid_rst_pop_data", pop_data_o, 8'h00);
    check("mid_rst_count", count_o, 3'd0);
    check("mid_rst_almost_full", almost_full_o, 1'b0);
    check("mid_rst_almost_empty", almost_empty_o, exp_ae_reset());
    model_q.delete();
    sb_q.delete();
    push_valid = 1'b0;
    pop_grant  = 1'b0;
    @(posedge clk);
    #2;
    check("held_rst_count", count_o, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    idle();

    // Randomised traffic, occasional flush.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), DW'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end

    // Drain whatever remains (bounded), then confirm nothing is owed.
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    idle();
    check("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
